// File: rtl/demux1_to_4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demux.
// Channel codes match the select encoding of the 4-to-1 mux.
package demux1_to_4_stream_pkg;

  localparam int NUM_CH     = 4;
  localparam int SEL_W      = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int FCNT_W     = 2;

  typedef enum logic [SEL_W-1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2,
    CH3 = 2'd3
  } chan_e;

  function automatic logic [NUM_CH-1:0] sel_onehot(
    input logic [SEL_W-1:0] s
  );
    logic [NUM_CH-1:0] oh;
    oh = '0;
    unique case (chan_e'(s))
      CH0: oh = 4'b0001;
      CH1: oh = 4'b0010;
      CH2: oh = 4'b0100;
      CH3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux1_to_4_stream_chan_fifo.sv
// Two-entry per-channel FIFO; head slot drives dout directly
// so the output word holds its last value once drained.
module demux_chan_fifo
  import demux1_to_4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [FCNT_W-1:0] count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  head_q;
  logic [WIDTH-1:0]  tail_q;
  logic [FCNT_W-1:0] cnt_q;
  logic              do_push;
  logic              do_pop;

  // Guard handshakes against over/underflow.
  always_comb begin
    full    = (cnt_q == FCNT_W'(FIFO_DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Shift-style storage: slot 0 is always the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (empty) head_q <= din;
          else       tail_q <= din;
          cnt_q <= cnt_q + 1'b1;
        end
        2'b01: begin
          if (full) head_q <= tail_q;
          cnt_q <= cnt_q - 1'b1;
        end
        2'b11: begin
          head_q <= din;
        end
        default: begin
        end
      endcase
    end
  end

  assign dout  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/demux1_to_4_stream.sv
// Registered 1-to-4 stream demux with per-channel 2-deep
// buffering and wrapping delivered-word counters.
module demux1_to_4_stream
  import demux1_to_4_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [WIDTH-1:0]    in_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*WIDTH-1:0]  out_data,
  output logic [4*CNT_W-1:0]  out_count
);

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [FCNT_W-1:0] fcnt [NUM_CH];
  logic [WIDTH-1:0]  dout [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];

  // Ready depends only on registered fill level of the target.
  always_comb begin
    in_ready = (fcnt[in_sel] < FCNT_W'(FIFO_DEPTH));
    push     = '0;
    if (in_valid && in_ready)
      push = sel_onehot(in_sel) & ~full;
    out_valid = ~empty;
    pop       = out_valid & out_ready;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      demux_chan_fifo #(
        .WIDTH(WIDTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push[k]),
        .pop   (pop[k]),
        .din   (in_data),
        .dout  (dout[k]),
        .count (fcnt[k]),
        .full  (full[k]),
        .empty (empty[k])
      );

      // Count delivered words; wraps silently.
      always_ff @(posedge clk) begin
        if (reset)       cnt_q[k] <= '0;
        else if (pop[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
      end

      assign out_data[k*WIDTH +: WIDTH]  = dout[k];
      assign out_count[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  endgenerate

endmodule
